fdiv_seq: RTL and testbench
===========================

Name: fdiv_seq

Overview:
Iterative IEEE-754 single-precision divider that executes the FPU pipeline's fdiv operations. The pipeline issues a start with two operands; this block raises busy and holds the integer unit stalled. It exposes a down-counter, cnt_div, for pipeline debug and testbench visibility. When the counter finishes it returns a rounded result with a one-cycle done pulse. Radix-2 restoring mantissa division, round-to-nearest-even only, flush-to-zero.

Parameters:
ITER, 26, quotient bits generated: 1 integer, 23 fraction, guard, round.
BIAS, 127, exponent bias.

Ports:
clk  input  1  clock, rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  divide request; accepted only when busy=0
a  input  32  dividend, IEEE single
b  input  32  divisor, IEEE single
s  output  32  quotient; valid when done=1, held until the next acceptance
busy  output  1  divide in progress; the pipeline stalls on it
done  output  1  one-cycle pulse: s is valid
cnt_div  output  5  remaining iterations; 0 when idle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, clrn.
- Reset values: s=0, busy=0, done=0, cnt_div=0. All internal mantissa, remainder and exponent registers are cleared.
- Reset mid-operation: all outputs clear immediately. No done is produced for the aborted operation.
- States: IDLE (busy=0) and DIV (busy=1). done is a registered pulse asserted on the exit edge.
- Accept (edge where start=1 and busy=0):
  - Latch sign = a[31]^b[31].
  - Latch mantissas 1.f, and exponent difference ea-eb+BIAS in 10-bit signed.
  - Latch the special-case class.
  - busy<=1, cnt_div<=ITER, done<=0.
- Start while busy=1 is ignored; the operands are not sampled.
- Start in the same cycle done=1 is accepted, since busy is already 0.
- Iterate (each edge with busy=1):
  - One restoring step: trial = rem - divisor. If trial>=0, the quotient bit is 1 and rem=trial; otherwise the quotient bit is 0.
  - rem is shifted left 1; cnt_div decrements.
- Finish (edge where busy=1 and cnt_div==1): the last step is folded in, then the result is normalised, rounded and packed into s. busy<=0, cnt_div<=0, done<=1.
- Latency: busy is high for exactly ITER=26 cycles. done rises 26 edges after the accepting edge, independent of operand values, including special cases.
- Normalisation: if q[25]=0 (quotient <1), shift q left 1 and decrement exponent by 1.
- Rounding: guard = next bit below the LSB; sticky = OR of the lower bits | (rem!=0). Round up when guard & (sticky | lsb). A mantissa carry-out renormalises and increments the exponent.
- Exponent range:
  - Final exponent >=255: s = signed infinity.
  - Final exponent <=0: s = signed zero (no denormal output).
- Input classes: a denormal input (exp=0) is treated as zero.
- Special-case priority (first match wins):
  1. Any NaN input, 0/0, or inf/inf: s = 0x7FC00000.
  2. inf/x or x/0: signed infinity.
  3. 0/x or x/inf: signed zero.
- No exception flags are produced.

Decomposition:
- Shared package / include header: QNAN=32'h7FC00000, POS_INF=32'h7F800000, BIAS, ITER, and operand-class encodings (ZERO, NORM, INF, NAN).
- Sub-module fdiv_round: combinational normalise + RNE + overflow/underflow + pack. Inputs: sign, 10-bit exponent, 26-bit quotient, rem_nz. Output: 32-bit result.
- The FSM, counter and restoring datapath stay in fdiv_seq.

Test Plan:
1. a=40C00000 (6.0), b=40000000 (2.0), start one cycle -> cnt_div steps 26..1, busy high 26 cycles, then done=1 with s=40400000. cnt_div=0 afterwards.
2. a=3F800000, b=40400000 (1/3) -> s=3EAAAAAB (RNE round-up). Also a=3F800000, b=3F800000 -> s=3F800000.
3. Special cases, each with 26-cycle latency:
   - 3F800000/00000000 -> 7F800000
   - BF800000/00000000 -> FF800000
   - 00000000/00000000 -> 7FC00000
   - 7F800000/7F800000 -> 7FC00000
   - 00000000/40000000 -> 00000000
4. Range limits:
   - Overflow: 7F000000/00800000 -> 7F800000.
   - Underflow: 00800000/7F000000 -> 00000000.
   - Denormal: 00000001/3F800000 -> 00000000.
5. Handshake:
   - start=1 held with new operands while busy -> ignored; s matches the first operation.
   - start asserted in the done cycle -> accepted; busy=1 and cnt_div=26 on the next cycle.
6. Reset: clrn pulsed low when cnt_div=10 -> s, busy, done, cnt_div are 0 before the next edge. No done afterwards until a new start.

Source files
------------

// File: rtl/fdiv_seq_pkg.sv
// Shared constants, operand/result classes and classification helpers for the
// iterative single-precision divider.
package fdiv_seq_pkg;

    localparam int unsigned ITER    = 26;
    localparam int unsigned BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {ClsZero, ClsNorm, ClsInf, ClsNan} op_cls_e;
    typedef enum logic [1:0] {ResNorm, ResZero, ResInf, ResNan} res_cls_e;

    // Denormals (exp == 0) are flushed and classified as zero.
    function automatic op_cls_e classify(input logic [30:0] x);
        if (x[30:23] == 8'h00) begin
            return ClsZero;
        end else if (x[30:23] == 8'hFF) begin
            return (x[22:0] == 23'd0) ? ClsInf : ClsNan;
        end
        return ClsNorm;
    endfunction

    // First match wins: NaN-producing cases, then infinity, then zero.
    function automatic res_cls_e special(input op_cls_e ca, input op_cls_e cb);
        if (ca == ClsNan || cb == ClsNan || (ca == ClsZero && cb == ClsZero) ||
            (ca == ClsInf && cb == ClsInf)) begin
            return ResNan;
        end else if (ca == ClsInf || cb == ClsZero) begin
            return ResInf;
        end else if (ca == ClsZero || cb == ClsInf) begin
            return ResZero;
        end
        return ResNorm;
    endfunction

endpackage

// File: rtl/fdiv_seq_if.sv
// Pipeline-side handshake of the divider: request, operands, result and status.
interface fdiv_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        busy;
    logic        done;
    logic [4:0]  cnt_div;

    modport master (output start, a, b, input s, busy, done, cnt_div);
    modport slave  (input start, a, b, output s, busy, done, cnt_div);
endinterface

// File: rtl/fdiv_seq_round.sv
// Normalise, round-to-nearest-even and pack a 26-bit restoring quotient;
// overflow saturates to infinity, underflow flushes to zero.
module fdiv_round import fdiv_seq_pkg::*; (
    input  logic              sign,
    input  logic signed [9:0] expo,
    input  logic [25:0]       q,
    input  logic              rem_nz,
    output logic [31:0]       res
);

    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic signed [9:0] exp_n;
    logic [22:0]       frac;

    always_comb begin
        mant   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        exp_n  = expo;
        if (q[25]) begin
            mant   = q[25:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
        end else begin
            // Quotient below 1.0: q[24] is guaranteed set since a/b > 0.5.
            mant   = q[24:1];
            guard  = q[0];
            sticky = rem_nz;
            exp_n  = expo - 10'sd1;
        end
        rnd_up = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd_up};
        frac   = mant_r[22:0];
        if (mant_r[24]) begin
            exp_n = exp_n + 10'sd1;
            frac  = mant_r[23:1];
        end
        if (exp_n >= 10'sd255) begin
            res = {sign, POS_INF[30:0]};
        end else if (exp_n <= 10'sd0) begin
            res = {sign, 31'd0};
        end else begin
            res = {sign, exp_n[7:0], frac};
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative radix-2 restoring IEEE single divider: fixed ITER-cycle latency,
// one quotient bit per cycle, RNE rounding, flush-to-zero.
module fdiv_seq import fdiv_seq_pkg::*; (
    input logic        clk,
    input logic        clrn,
    fdiv_seq_if.slave  bus
);

    typedef enum logic {StIdle, StDiv} state_e;

    state_e            state_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [23:0]       div_q;
    logic [25:0]       rem_q;
    logic [24:0]       quo_q;
    res_cls_e          cls_q;
    logic [4:0]        cnt_q;
    logic              done_q;
    logic [31:0]       s_q;

    logic [26:0]       trial;
    logic              ge;
    logic [25:0]       rem_step;
    logic [25:0]       quo_next;
    logic [31:0]       round_res;

    always_comb begin
        trial    = {1'b0, rem_q} - {3'b000, div_q};
        ge       = ~trial[26];
        rem_step = ge ? trial[25:0] : rem_q;
        quo_next = {quo_q, ge};
    end

    // Rounding sees the final step combinationally so it folds into the last edge.
    fdiv_round u_round (
        .sign   (sign_q),
        .expo   (exp_q),
        .q      (quo_next),
        .rem_nz (|rem_step),
        .res    (round_res)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cls_q   <= ResNorm;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            s_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sign_q  <= bus.a[31] ^ bus.b[31];
                        exp_q   <= {2'b00, bus.a[30:23]} - {2'b00, bus.b[30:23]} + 10'(BIAS);
                        rem_q   <= {2'b01, bus.a[22:0]};
                        div_q   <= {1'b1, bus.b[22:0]};
                        quo_q   <= '0;
                        cls_q   <= special(classify(bus.a[30:0]), classify(bus.b[30:0]));
                        cnt_q   <= 5'(ITER);
                        state_q <= StDiv;
                    end
                end
                StDiv: begin
                    rem_q <= {rem_step[24:0], 1'b0};
                    quo_q <= quo_next[24:0];
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        unique case (cls_q)
                            ResNorm: s_q <= round_res;
                            ResZero: s_q <= {sign_q, 31'd0};
                            ResInf:  s_q <= {sign_q, POS_INF[30:0]};
                            ResNan:  s_q <= QNAN;
                        endcase
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.s       = s_q;
    assign bus.busy    = (state_q == StDiv);
    assign bus.done    = done_q;
    assign bus.cnt_div = cnt_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed and randomized checks of fdiv_seq against an arithmetic reference model.
module tb_fdiv_seq;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    fdiv_seq_if bus ();

    fdiv_seq dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Exact quotient with 64-bit integer division, then RNE on the discarded bits.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        bit za = (ea == 0);
        bit zb = (eb == 0);
        bit ia = (ea == 255) && (a[22:0] == 23'd0);
        bit ib = (eb == 255) && (b[22:0] == 23'd0);
        bit na = (ea == 255) && (a[22:0] != 23'd0);
        bit nb = (eb == 255) && (b[22:0] != 23'd0);
        bit sg = a[31] ^ b[31];
        longint unsigned ma, mb, q, r, keep, rest, half;
        int e, sh;
        if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
        if (ia || zb) return {sg, 8'hFF, 23'd0};
        if (za || ib) return {sg, 31'd0};
        ma = 64'({1'b1, a[22:0]});
        mb = 64'({1'b1, b[22:0]});
        q  = (ma << 39) / mb;
        r  = (ma << 39) % mb;
        e  = ea - eb + 127;
        if (ma >= mb) sh = 16;
        else begin
            sh = 15;
            e--;
        end
        keep = q >> sh;
        rest = q & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rest > half || (rest == half && (r != 0 || keep[0]))) keep++;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        if (e <= 0) return {sg, 31'd0};
        return {sg, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned r = $urandom_range(0, 15);
        logic        sg = 1'($urandom);
        logic [22:0] fr = 23'($urandom);
        if (r == 0) return {sg, 31'd0};
        if (r == 1) return {sg, 8'hFF, 23'd0};
        if (r == 2) return {sg, 8'hFF, fr | 23'd1};
        if (r == 3) return {sg, 8'h00, fr};
        if (r < 12) return {sg, 8'($urandom_range(110, 144)), fr};
        return {sg, 8'($urandom_range(1, 254)), fr};
    endfunction

    // Waits for done; `elapsed` edges have already passed since the accepting edge.
    task automatic wait_done(input string tag, input logic [31:0] exp_s, input bit trace,
                             input int elapsed);
        int lat = 0;
        for (int k = elapsed + 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (trace) begin
                check({tag, " cnt"}, 32'(bus.cnt_div), 32'(26 - k));
                check({tag, " busy"}, 32'(bus.busy), 32'd1);
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd26);
        check({tag, " s"}, bus.s, exp_s);
        check({tag, " idle cnt"}, 32'(bus.cnt_div), 32'd0);
        check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic launch(input string tag, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " accept busy"}, 32'(bus.busy), 32'd1);
        check({tag, " accept cnt"}, 32'(bus.cnt_div), 32'd26);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_s, input bit trace);
        launch(tag, a, b);
        wait_done(tag, exp_s, trace, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          seen;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        #3;
        check("reset s", bus.s, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset cnt", 32'(bus.cnt_div), 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        run_div("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);
        run_div("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        run_div("1/1", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        run_div("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0);
        run_div("-1/0", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0);
        run_div("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
        run_div("inf/inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0);
        run_div("0/2", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0);
        run_div("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0);
        run_div("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);
        run_div("denorm", 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0);

        // New operands with start held high during busy must not disturb the operation.
        launch("held", 32'h40C00000, 32'h40000000);
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("held cnt", 32'(bus.cnt_div), 32'd21);
        wait_done("held", 32'h40400000, 1'b0, 5);

        // Start raised in the done cycle is accepted.
        check("done-cycle done", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("done-cycle busy", 32'(bus.busy), 32'd1);
        check("done-cycle cnt", 32'(bus.cnt_div), 32'd26);
        check("done-cycle done low", 32'(bus.done), 32'd0);
        wait_done("done-cycle", 32'h3EAAAAAB, 1'b0, 0);

        // Asynchronous reset mid-operation.
        launch("abort", 32'h40C00000, 32'h40000000);
        for (int k = 0; k < 40 && bus.cnt_div != 5'd10; k++) begin
            @(posedge clk);
            #1;
        end
        check("abort reached cnt", 32'(bus.cnt_div), 32'd10);
        #2;
        clrn = 1'b0;
        #1;
        check("abort s", bus.s, 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort cnt", 32'(bus.cnt_div), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("abort no done", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            run_div($sformatf("rnd%0d %h/%h", i, ra, rb), ra, rb, ref_div(ra, rb), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
